// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter.
// Holds the FSM state, the default memory size and the request bundle.
package ram_arbiter_pkg;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  localparam logic [63:0] RAM_WORDS_DEF = 64'h0C00_0000;

  typedef struct packed {
    logic        wen;
    logic [63:0] idx;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts at i_ptr and wraps.
// Produces a one-hot (or all-zero) grant vector.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic w_found;

  // first requester at or after the pointer wins
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && i_req[i] &&
            i == (int'(i_ptr) + k) % NREQ) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-requester single-port RAM arbiter, one transaction in flight.
// Define RAM_ARB_BOUND_CHECK_EN to reject indices >= RAM_WORDS.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter logic [63:0] RAM_WORDS = RAM_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_wen,
  input  logic [NREQ-1:0][63:0] req_idx,
  input  logic [NREQ-1:0][63:0] req_wdata,
  input  logic [NREQ-1:0][63:0] req_wmask,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [63:0]           mem_rIdx,
  output logic [63:0]           mem_wIdx,
  input  logic [63:0]           mem_rdata,
  output logic [63:0]           mem_wdata,
  output logic [63:0]           mem_wmask,
  output logic                  mem_wen
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          r_state;
  logic [PW-1:0]   r_rr;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_rr_nxt;
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_grant;
  logic            w_hs;
  logic            w_open;
  logic            w_any;
  logic            w_oob;
  req_t            w_sel;

  // owner's response completes this cycle
  assign w_hs   = (r_state == RESP) && resp_ready[r_owner];
  assign w_open = !reset && ((r_state == IDLE) || w_hs);
  assign w_req  = w_open ? req_valid : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_rr),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_any     = |w_grant;

  // encode winner and mux its request
  always_comb begin
    w_gidx = '0;
    w_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gidx      = PW'(i);
        w_sel.wen   = req_wen[i];
        w_sel.idx   = req_idx[i];
        w_sel.wdata = req_wdata[i];
        w_sel.wmask = req_wmask[i];
      end
    end
  end

  assign w_rr_nxt = (w_gidx == PW'(NREQ - 1)) ?
                    '0 : w_gidx + 1'b1;

`ifdef RAM_ARB_BOUND_CHECK_EN
  assign w_oob = w_any && (w_sel.idx >= RAM_WORDS);
`else
  assign w_oob = 1'b0;
`endif

  assign mem_en    = w_any && !w_oob;
  assign mem_wen   = mem_en && w_sel.wen;
  assign mem_rIdx  = mem_en ? w_sel.idx : '0;
  assign mem_wIdx  = mem_en ? w_sel.idx : '0;
  assign mem_wdata = mem_en ? w_sel.wdata : '0;
  assign mem_wmask = mem_en ? w_sel.wmask : '0;

  // FSM: grant captures read data, handshake alone frees
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr       <= '0;
      r_owner    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (w_any) begin
      r_state    <= RESP;
      r_owner    <= w_gidx;
      r_rr       <= w_rr_nxt;
      resp_rdata <= w_oob ? '0 : mem_rdata;
      resp_err   <= w_oob;
    end else if (w_hs) begin
      r_state <= IDLE;
    end
  end

  // only the owner sees a pending response
  always_comb begin
    resp_valid = '0;
    if (r_state == RESP) resp_valid[r_owner] = 1'b1;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed cases then random traffic.
// Honors RAM_ARB_BOUND_CHECK_EN in its reference model.
module tb_ram_arbiter;

  localparam int          NREQ = 2;
  localparam logic [63:0] RW   = 64'h0C00_0000;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid, req_ready, req_wen;
  logic [NREQ-1:0][63:0] req_idx, req_wdata, req_wmask;
  logic [NREQ-1:0]       resp_valid, resp_ready;
  logic [63:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_en, mem_wen;
  logic [63:0]           mem_rIdx, mem_wIdx, mem_wdata, mem_wmask;
  logic [63:0]           mem_rdata = '0;

  ram_arbiter #(.NREQ(NREQ), .RAM_WORDS(RW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_idx(req_idx),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_rIdx(mem_rIdx), .mem_wIdx(mem_wIdx),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t            q[$];
  int              grants[$];
  logic [63:0]     env_mem[logic [63:0]];
  logic [63:0]     ref_mem[logic [63:0]];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              rr = 0;
  logic [NREQ-1:0] last_eg;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] env_rd(logic [63:0] a);
    return env_mem.exists(a) ? env_mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] ref_rd(logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  // inputs are set at negedge; predict and check this cycle's grant
  task automatic step();
    int          w;
    bit          can, oob;
    logic [63:0] a, old, wd, wm;
    #1;
    mem_rdata = env_rd(mem_rIdx);
    last_eg = '0;
    w = -1;
    oob = 1'b0;
    if (reset) begin
      rr = 0;
      chk("req_ready_rst", req_ready, '0);
      chk("mem_en_rst", mem_en, 0);
      chk("mem_wen_rst", mem_wen, 0);
    end else begin
      can = (q.size() == 0) || resp_ready[q[0].who];
      if (can)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(rr + k) % NREQ]) w = (rr + k) % NREQ;
      if (w >= 0) begin
        last_eg[w] = 1'b1;
        a  = req_idx[w];
        wd = req_wdata[w];
        wm = req_wmask[w];
`ifdef RAM_ARB_BOUND_CHECK_EN
        oob = (a >= RW);
`endif
        old = ref_rd(a);
        q.push_back('{who: w, rdata: oob ? 64'h0 : old,
                      err: oob, cyc: cyc});
        if (!oob && req_wen[w]) ref_mem[a] = (old & ~wm) | (wd & wm);
        rr = (w + 1) % NREQ;
        grants.push_back(w);
      end
      chk("req_ready", req_ready, last_eg);
      chk("mem_en", mem_en, (w >= 0 && !oob));
      if (w >= 0 && !oob) begin
        chk("mem_rIdx", mem_rIdx, a);
        chk("mem_wIdx", mem_wIdx, a);
        chk("mem_wdata", mem_wdata, wd);
        chk("mem_wmask", mem_wmask, wm);
        chk("mem_wen", mem_wen, req_wen[w]);
      end else begin
        chk("mem_wen_idle", mem_wen, 0);
        chk("mem_idx_idle", mem_rIdx, 0);
      end
    end
    if (mem_wen)
      env_mem[mem_wIdx] = (env_rd(mem_wIdx) & ~mem_wmask) |
                          (mem_wdata & mem_wmask);
    @(negedge clk);
  endtask

  task automatic rq(int who, bit wen, logic [63:0] a,
                    logic [63:0] wd, logic [63:0] wm);
    req_valid[who] = 1'b1;
    req_wen[who]   = wen;
    req_idx[who]   = a;
    req_wdata[who] = wd;
    req_wmask[who] = wm;
  endtask

  // monitor: compare the presented response against the queue head
  initial begin
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge clk);
      #2;
      ev = '0;
      if (reset) begin
        q.delete();
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        ev[q[0].who] = 1'b1;
        chk("resp_valid", resp_valid, ev);
        chk("resp_rdata", resp_rdata, q[0].rdata);
        chk("resp_err", resp_err, q[0].err);
        if (resp_ready[q[0].who]) void'(q.pop_front());
      end else begin
        chk("resp_valid_idle", resp_valid, ev);
      end
    end
  end

  initial begin
    env_mem[64'h10] = 64'hDEAD_BEEF;
    ref_mem[64'h10] = 64'hDEAD_BEEF;
    reset      = 1'b1;
    req_valid  = '0;
    req_wen    = '0;
    req_idx    = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = '1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_valid", resp_valid, 0);
    step();

    rq(0, 1'b0, 64'h10, 0, 0);
    step();
    req_valid = '0;
    chk("rd0_valid", resp_valid, 2'b01);
    chk("rd0_data", resp_rdata, 64'hDEAD_BEEF);

    rq(1, 1'b1, 64'h10, 64'hFFFF_0000_1234_5678, 64'h0000_0000_FFFF_FFFF);
    step();
    req_valid = '0;
    chk("wr1_old", resp_rdata, 64'hDEAD_BEEF);
    rq(1, 1'b0, 64'h10, 0, 0);
    step();
    req_valid = '0;
    chk("rd1_new", resp_rdata, 64'h0000_0000_1234_5678);

    grants.delete();
    rq(0, 1'b0, 64'h3, 0, 0);
    rq(1, 1'b0, 64'h4, 0, 0);
    repeat (4) step();
    req_valid = '0;
    chk("alt_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("alt_order", grants[i], i % 2);

    rq(0, 1'b0, 64'h10, 0, 0);
    step();
    rq(1, 1'b0, 64'h5, 0, 0);
    resp_ready = 2'b10;
    repeat (3) begin
      step();
      chk("hold_valid", resp_valid, 2'b01);
      chk("hold_data", resp_rdata, 64'h0000_0000_1234_5678);
    end
    resp_ready = '1;
    step();
    req_valid = '0;

    reset = 1'b1;
    resp_ready = '0;
    step();
    reset = 1'b0;
    chk("rst_mid_valid", resp_valid, 0);
    grants.delete();
    resp_ready = '1;
    rq(0, 1'b0, 64'h1, 0, 0);
    rq(1, 1'b0, 64'h2, 0, 0);
    step();
    req_valid = '0;
    chk("rst_mid_grant", grants.size() > 0 ? grants[0] : -1, 0);

    rq(0, 1'b0, RW, 0, 0);
    step();
    req_valid = '0;
`ifdef RAM_ARB_BOUND_CHECK_EN
    chk("oob_err", resp_err, 1);
    chk("oob_data", resp_rdata, 0);
`else
    chk("oob_err", resp_err, 0);
`endif

    repeat (400) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          logic [63:0] a;
          a = 64'($urandom_range(0, 20));
          if ($urandom_range(0, 15) == 0) a = RW - 1 + 64'($urandom_range(0, 1));
          rq(i, 1'($urandom_range(0, 1)), a,
             {$urandom, $urandom}, {$urandom, $urandom});
        end
      resp_ready = NREQ'($urandom);
      step();
      req_valid = req_valid & ~last_eg;
    end

    req_valid  = '0;
    resp_ready = '1;
    repeat (3) step();
    chk("drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
